uart_rx_param: RTL

Parametrised UART receiver, the successor to the fixed 8N1 receiver in the RS232 project. Baud rate, data width, parity mode and stop-bit count are set by parameters. Each bit is recovered by majority vote, and the block flags parity and framing errors. It sits between the board RX pin and the downstream loopback/FIFO logic, and presents each received word as a one-cycle strobe.

---
 rtl/uart_rx_param.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority voting.
//
// Frame: start bit, DATA_BITS payload bits (LSB first), optional parity bit
// (PARITY: 0 none, 1 odd, 2 even), then STOP_BITS stop bits. Each bit is sampled
// at MID-1, MID and MID+1 of its bit period and resolved by majority.
//
// Ports:
//   sys_clk    - system clock, rising edge
//   sys_rst    - synchronous reset, active high
//   rx         - asynchronous serial input, idles high
//   po_data    - received payload, held until the next po_flag
//   po_flag    - one-cycle strobe: po_data / parity_err / frame_err valid
//   parity_err - parity mismatch on the frame just strobed
//   frame_err  - some stop bit of the frame just strobed was low
//   busy       - high from start-edge detection until back in idle
module uart_rx_param #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] po_data,
   output logic                 po_flag,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned BitCntMax = CLK_FREQ / BAUD;
   localparam int unsigned Mid       = BitCntMax / 2;
   localparam int unsigned CntW      = (BitCntMax > 1) ? $clog2(BitCntMax) : 1;
   localparam int unsigned IdxW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CntW-1:0] CntLast  = CntW'(BitCntMax - 1);
   localparam logic [CntW-1:0] CntSampA = CntW'(Mid - 1);
   localparam logic [CntW-1:0] CntSampB = CntW'(Mid);
   localparam logic [CntW-1:0] CntEval  = CntW'(Mid + 1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);
   localparam logic            StopLast = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic                 r_rx_s1;
   logic                 r_rx_s2;
   logic                 r_rx_s3;
   logic [CntW-1:0]      r_bit_cnt;
   logic [1:0]           r_samp;
   logic [IdxW-1:0]      r_bit_idx;
   logic                 r_stop_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_acc;
   logic                 r_perr;
   logic                 r_ferr;
   logic [DATA_BITS-1:0] r_po_data;
   logic                 r_po_flag;
   logic                 r_parity_err;
   logic                 r_frame_err;

   logic w_fall;
   logic w_eval;
   logic w_maj;
   logic w_load;
   logic w_busy;

   assign w_fall = r_rx_s3 & ~r_rx_s2;
   assign w_eval = (r_bit_cnt == CntEval);
   // Third sample is the live synchroniser output at MID+1.
   assign w_maj  = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s2) | (r_samp[1] & r_rx_s2);

   // State register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_fall) w_state_nxt = StStart;
         end
         StStart: begin
            if (w_eval) w_state_nxt = w_maj ? StIdle : StData;
         end
         StData: begin
            if (w_eval && (r_bit_idx == IdxLast)) begin
               w_state_nxt = (PARITY != 0) ? StParity : StStop;
            end
         end
         StParity: begin
            if (w_eval) w_state_nxt = StStop;
         end
         StStop: begin
            // Leave at mid-stop so a back-to-back start edge is caught.
            if (w_eval && (r_stop_idx == StopLast)) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Output decode
   always_comb begin
      w_busy = (r_state != StIdle);
      w_load = (r_state == StStop) && w_eval && (r_stop_idx == StopLast);
   end

   // Synchroniser, bit timing and datapath
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_rx_s1      <= 1'b1;
         r_rx_s2      <= 1'b1;
         r_rx_s3      <= 1'b1;
         r_bit_cnt    <= '0;
         r_samp       <= 2'b11;
         r_bit_idx    <= '0;
         r_stop_idx   <= 1'b0;
         r_shift      <= '0;
         r_par_acc    <= 1'b0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         r_po_data    <= '0;
         r_po_flag    <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_rx_s1   <= rx;
         r_rx_s2   <= r_rx_s1;
         r_rx_s3   <= r_rx_s2;
         r_po_flag <= w_load;

         // Counter sits at 0 in idle, so it is zero the cycle after the edge.
         if (r_state == StIdle || r_bit_cnt == CntLast) begin
            r_bit_cnt <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + CntW'(1);
         end

         if (r_bit_cnt == CntSampA) r_samp[0] <= r_rx_s2;
         if (r_bit_cnt == CntSampB) r_samp[1] <= r_rx_s2;

         case (r_state)
            StIdle: begin
               if (w_fall) begin
                  r_bit_idx  <= '0;
                  r_stop_idx <= 1'b0;
                  r_par_acc  <= 1'b0;
                  r_perr     <= 1'b0;
                  r_ferr     <= 1'b0;
               end
            end
            StData: begin
               if (w_eval) begin
                  r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                  r_par_acc <= r_par_acc ^ w_maj;
                  r_bit_idx <= r_bit_idx + IdxW'(1);
               end
            end
            StParity: begin
               if (w_eval) begin
                  // Odd parity wants an odd total of ones, even wants even.
                  if (PARITY == 1) r_perr <= ~(r_par_acc ^ w_maj);
                  else             r_perr <= r_par_acc ^ w_maj;
               end
            end
            StStop: begin
               if (w_eval) begin
                  if (!w_maj) r_ferr <= 1'b1;
                  r_stop_idx <= ~r_stop_idx;
                  if (w_load) begin
                     r_po_data    <= r_shift;
                     r_parity_err <= r_perr;
                     r_frame_err  <= r_ferr | ~w_maj;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign po_data    = r_po_data;
   assign po_flag    = r_po_flag;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign busy       = w_busy;

endmodule
